// File: rtl/udp_rx_depacketizer_if.sv
// ---------------------------------------------------------------------------
// udp_rx_depacketizer_pkg / udp_rx_depacketizer_if
//
// Purpose: shared types for the UDP receive depacketizer and the byte-stream
// bus interface used on both its input (IPv4 payload) and output (UDP payload).
//
// Bus signals (one beat per clock):
//   start        first beat of a frame
//   data_valid   data/bytes_valid carry payload this beat
//   bytes_valid  0..16 valid bytes, left-aligned at data[127:120]
//   data         128-bit beat, MSB-first
//   commit       frame ended and is good
//   drop         frame ended and must be discarded
// ---------------------------------------------------------------------------
package udp_rx_depacketizer_pkg;

    typedef struct packed {
        logic [15:0] payload_len;
        logic [7:0]  protocol;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } ipv4_hdr_t;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] payload_len;
        logic [15:0] checksum;
    } udp_hdr_t;

    typedef struct packed {
        logic         start;
        logic         data_valid;
        logic [4:0]   bytes_valid;
        logic [127:0] data;
        logic         commit;
        logic         drop;
    } eth_bus_t;

endpackage

interface udp_rx_depacketizer_if;
    logic         start;
    logic         data_valid;
    logic [4:0]   bytes_valid;
    logic [127:0] data;
    logic         commit;
    logic         drop;

    modport master (output start, data_valid, bytes_valid, data, commit, drop);
    modport slave  (input  start, data_valid, bytes_valid, data, commit, drop);
endinterface

// File: rtl/udp_rx_depacketizer.sv
// ---------------------------------------------------------------------------
// udp_rx_depacketizer
//
// Strips the 8-byte UDP header from an IPv4 payload stream and realigns the
// UDP payload so its first byte sits at data[127:120]. Frames that are not
// UDP or whose UDP length is inconsistent are rejected and swallowed.
//
// Ports:
//   rx_clk          clock, rising edge
//   rx_rst_n        asynchronous active-low reset
//   rx_l3_bus       (slave)  IPv4 payload stream in
//   rx_l3_headers   IPv4 header fields, stable for the whole frame
//   rx_udp_headers  UDP header fields, valid from output start to next start
//   rx_udp_bus      (master) realigned UDP payload stream out
//   rx_udp_reject   one-cycle pulse when a frame is rejected
//
// All outputs are registered; output follows input by one cycle, except
// that a frame whose tail is still held in the carry register needs one
// extra FLUSH cycle after the input commit.
// ---------------------------------------------------------------------------
module udp_rx_depacketizer
    import udp_rx_depacketizer_pkg::*;
(
    input  logic                         rx_clk,
    input  logic                         rx_rst_n,
    udp_rx_depacketizer_if.slave         rx_l3_bus,
    input  ipv4_hdr_t                    rx_l3_headers,
    output udp_hdr_t                     rx_udp_headers,
    udp_rx_depacketizer_if.master        rx_udp_bus,
    output logic                         rx_udp_reject
);

    typedef enum logic [1:0] {IDLE, BODY, FLUSH, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [63:0] carry_q, carry_d;
    logic [4:0]  cnt_q, cnt_d;        // valid bytes held in carry_q
    logic [15:0] rem_q, rem_d;        // UDP payload bytes still to emit
    udp_hdr_t    hdr_q, hdr_d;
    eth_bus_t    out_q, out_d;
    logic        rej_q, rej_d;

    logic [4:0]  b_in, b_lo, b_hi, raw, emit, flush_cnt;
    logic [15:0] rem_after, udp_len;
    logic        start_ok, accept, do_start;

    // Input beat split: the upper 8 bytes complete the carried half-word,
    // the lower 8 bytes become the next carry.
    always_comb begin
        if (!rx_l3_bus.data_valid)
            b_in = 5'd0;
        else if (rx_l3_bus.bytes_valid > 5'd16)
            b_in = 5'd16;
        else
            b_in = rx_l3_bus.bytes_valid;
        b_lo = (b_in > 5'd8) ? 5'd8 : b_in;
        b_hi = (b_in > 5'd8) ? (b_in - 5'd8) : 5'd0;
        raw  = cnt_q + b_lo;
        // Trimming to the remaining UDP length is what strips Ethernet padding.
        emit      = ({11'd0, raw} > rem_q) ? rem_q[4:0] : raw;
        rem_after = rem_q - {11'd0, emit};
        flush_cnt = ({11'd0, cnt_q} > rem_q) ? rem_q[4:0] : cnt_q;

        start_ok = rx_l3_bus.start && rx_l3_bus.data_valid;
        udp_len  = rx_l3_bus.data[95:80];
        accept   = (rx_l3_headers.protocol == 8'd17) &&
                   (rx_l3_bus.bytes_valid >= 5'd8) &&
                   (udp_len >= 16'd8) &&
                   (udp_len <= rx_l3_headers.payload_len);
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q <= IDLE;
            carry_q <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            hdr_q   <= '0;
            out_q   <= '0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            hdr_q   <= hdr_d;
            out_q   <= out_d;
            rej_q   <= rej_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        hdr_d    = hdr_q;
        out_d    = '0;
        rej_d    = 1'b0;
        do_start = 1'b0;

        case (state_q)
            IDLE: begin
                do_start = start_ok;
            end

            DISCARD: begin
                // A fresh start ends the discarded frame just as well as
                // its own commit/drop would.
                if (start_ok)
                    do_start = 1'b1;
                else if (rx_l3_bus.commit || rx_l3_bus.drop)
                    state_d = IDLE;
            end

            BODY: begin
                if (rx_l3_bus.start) begin
                    // Current frame never saw its end: abandon it. An
                    // accepted new start goes out on this same beat.
                    out_d.drop = 1'b1;
                    state_d    = IDLE;
                    do_start   = start_ok;
                end else if (rx_l3_bus.drop) begin
                    out_d.drop = 1'b1;
                    state_d    = IDLE;
                end else if (rx_l3_bus.data_valid || rx_l3_bus.commit) begin
                    // A bare commit is treated as a zero-byte beat so any
                    // carried bytes still get emitted.
                    out_d.data        = {carry_q, rx_l3_bus.data[127:64]};
                    out_d.bytes_valid = emit;
                    out_d.data_valid  = (emit != 5'd0);
                    carry_d           = rx_l3_bus.data[63:0];
                    cnt_d             = b_hi;
                    rem_d             = rem_after;
                    if (rx_l3_bus.commit) begin
                        if (rem_after == 16'd0) begin
                            out_d.commit = 1'b1;
                            state_d      = IDLE;
                        end else if (b_hi == 5'd0) begin
                            // Input ended short of the UDP length.
                            out_d.drop = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = FLUSH;
                        end
                    end
                end
            end

            FLUSH: begin
                if (rx_l3_bus.drop) begin
                    out_d.drop = 1'b1;
                    state_d    = IDLE;
                end else begin
                    out_d.data        = {carry_q, 64'h0};
                    out_d.bytes_valid = flush_cnt;
                    out_d.data_valid  = (flush_cnt != 5'd0);
                    // Carry cannot cover the remaining length: truncated.
                    if ({11'd0, cnt_q} < rem_q)
                        out_d.drop = 1'b1;
                    else
                        out_d.commit = 1'b1;
                    rem_d   = rem_q - {11'd0, flush_cnt};
                    cnt_d   = 5'd0;
                    state_d = IDLE;
                    // No room to open a frame while the previous one is
                    // still draining, so a start here is refused.
                    if (rx_l3_bus.start) begin
                        rej_d   = 1'b1;
                        state_d = (rx_l3_bus.commit) ? IDLE : DISCARD;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        if (do_start) begin
            if (accept) begin
                carry_d = rx_l3_bus.data[63:0];
                cnt_d   = b_hi;
                rem_d   = udp_len - 16'd8;
                if (rx_l3_bus.drop) begin
                    state_d = IDLE;
                end else begin
                    out_d.start       = 1'b1;
                    hdr_d.src_ip      = rx_l3_headers.src_ip;
                    hdr_d.dst_ip      = rx_l3_headers.dst_ip;
                    hdr_d.src_port    = rx_l3_bus.data[127:112];
                    hdr_d.dst_port    = rx_l3_bus.data[111:96];
                    hdr_d.payload_len = udp_len - 16'd8;
                    hdr_d.checksum    = rx_l3_bus.data[79:64];
                    // Commit on the header beat still needs FLUSH for the
                    // carried bytes (or an empty commit when udp_len==8).
                    state_d = rx_l3_bus.commit ? FLUSH : BODY;
                end
            end else begin
                rej_d   = 1'b1;
                cnt_d   = 5'd0;
                rem_d   = 16'd0;
                state_d = (rx_l3_bus.commit || rx_l3_bus.drop) ? IDLE : DISCARD;
            end
        end
    end

    assign rx_udp_bus.start       = out_q.start;
    assign rx_udp_bus.data_valid  = out_q.data_valid;
    assign rx_udp_bus.bytes_valid = out_q.bytes_valid;
    assign rx_udp_bus.data        = out_q.data;
    assign rx_udp_bus.commit      = out_q.commit;
    assign rx_udp_bus.drop        = out_q.drop;
    assign rx_udp_headers         = hdr_q;
    assign rx_udp_reject          = rej_q;

endmodule
